// File: rtl/fp_normalize_round_pkg.sv
// fp_normalize_round_pkg: shared float widths, constants and FSM encodings.
// Imported by fp_normalize_round and fp_round_rne.
package fp_normalize_round_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_IN_W   = 48;
    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_MAX = (1 << FP_EXP_W) - 1;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // one normalization action per SHIFT cycle
    typedef enum logic [2:0] {
        ACT_RND  = 3'd0,
        ACT_ZERO = 3'd1,
        ACT_RSH  = 3'd2,
        ACT_LSH  = 3'd3,
        ACT_DEN  = 3'd4
    } act_t;

endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational round-to-nearest-even on the kept significand.
// Reports carry-out of the kept bits and the inexact condition.
module fp_round_rne
    import fp_normalize_round_pkg::*;
#(
    parameter int KW = FP_MANT_W + 1
) (
    input  logic [KW-1:0] kept,
    input  logic          guard,
    input  logic          sticky,
    output logic [KW-1:0] rounded,
    output logic          carry,
    output logic          inexact
);

    logic        up;
    logic [KW:0] sum;

    assign up      = guard & (sticky | kept[0]);
    assign sum     = {1'b0, kept} + {{KW{1'b0}}, up};
    assign rounded = sum[KW-1:0];
    assign carry   = sum[KW];
    assign inexact = guard | sticky;

endmodule

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: serial normalize, RNE round and pack of a raw significand.
// Define FP_SUBNORMAL_EN to produce subnormals instead of flushing to zero.
module fp_normalize_round
    import fp_normalize_round_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W,
    parameter int IN_W   = FP_IN_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      sign_in,
    input  logic [EXP_W+1:0]          exp_in,
    input  logic [IN_W-1:0]           sig_in,
    output logic                      busy,
    output logic                      done,
    output logic [EXP_W+MANT_W:0]     result,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      inexact
);

    localparam int KW = MANT_W + 1;
    localparam int EW = EXP_W + 4;
    localparam int GB = IN_W - 2 - KW;
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    state_t state, state_nx;
    act_t   act;

    logic [IN_W-1:0] sig_q;
    logic [EW-1:0]   exp_q;
    logic            sign_q, sticky_q, zero_q, sub_q, inex_q;
    logic [KW-1:0]   mant_q;

    logic [KW-1:0]   r_mant;
    logic            r_carry, r_inex;
    logic            exp_le0, exp_ovf, den_sh;

    logic [EXP_W+MANT_W:0] pk_res;
    logic [EXP_W-1:0]      pk_exp;
    logic                  pk_ovf, pk_unf, pk_inex;

    // exp_q is two's complement; wide enough for every shift and carry
    assign exp_le0 = exp_q[EW-1] | (exp_q == '0);
    assign exp_ovf = !exp_q[EW-1] && (exp_q >= EMAX);
    assign busy    = (state != ST_IDLE);

`ifdef FP_SUBNORMAL_EN
    logic norm;
    assign norm   = (sig_q[IN_W-1 -: 2] == 2'b01);
    assign den_sh = (sub_q | norm) & exp_le0;
`else
    assign den_sh = 1'b0;
`endif

    fp_round_rne #(.KW(KW)) u_rne (
        .kept    (sig_q[IN_W-2 -: KW]),
        .guard   (sig_q[GB]),
        .sticky  (sticky_q | (|sig_q[GB-1:0])),
        .rounded (r_mant),
        .carry   (r_carry),
        .inexact (r_inex)
    );

    always_comb begin
        act = ACT_RND;
        if (den_sh)                act = ACT_DEN;
        else if (sub_q)            act = ACT_RND;
        else if (sig_q == '0)      act = ACT_ZERO;
        else if (sig_q[IN_W-1])    act = ACT_RSH;
        else if (!sig_q[IN_W-2])   act = ACT_LSH;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_SHIFT;
            ST_SHIFT: begin
                if (act == ACT_ZERO)     state_nx = ST_DONE;
                else if (act == ACT_RND) state_nx = ST_ROUND;
            end
            ST_ROUND: state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        pk_res  = {sign_q, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
        pk_exp  = exp_q[EXP_W-1:0];
        pk_ovf  = 1'b0;
        pk_unf  = 1'b0;
        pk_inex = 1'b0;
        if (zero_q) begin
            pk_inex = 1'b0;
        end else if (exp_ovf) begin
            pk_res  = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            pk_ovf  = 1'b1;
            pk_inex = inex_q;
        end else if (exp_le0) begin
            pk_unf  = 1'b1;
            pk_inex = 1'b1;
        end else begin
            // no hidden bit after rounding means the value stayed subnormal
            if (!mant_q[MANT_W]) pk_exp = '0;
            pk_res  = {sign_q, pk_exp, mant_q[MANT_W-1:0]};
            pk_unf  = sub_q & inex_q;
            pk_inex = inex_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sig_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            sticky_q  <= 1'b0;
            zero_q    <= 1'b0;
            sub_q     <= 1'b0;
            inex_q    <= 1'b0;
            mant_q    <= '0;
            done      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            unique case (state)
                ST_IDLE: if (start) begin
                    sig_q    <= sig_in;
                    exp_q    <= {{2{exp_in[EXP_W+1]}}, exp_in};
                    sign_q   <= sign_in;
                    sticky_q <= 1'b0;
                    zero_q   <= 1'b0;
                    sub_q    <= 1'b0;
                end
                ST_SHIFT: begin
                    unique case (act)
                        ACT_DEN, ACT_RSH: begin
                            sig_q    <= sig_q >> 1;
                            sticky_q <= sticky_q | sig_q[0];
                            exp_q    <= exp_q + EW'(1);
                            if (act == ACT_DEN) sub_q <= 1'b1;
                        end
                        ACT_LSH: begin
                            sig_q <= sig_q << 1;
                            exp_q <= exp_q - EW'(1);
                        end
                        ACT_ZERO: zero_q <= 1'b1;
                        ACT_RND:  zero_q <= 1'b0;
                        default:  zero_q <= 1'b0;
                    endcase
                end
                ST_ROUND: begin
                    mant_q <= r_carry ? {1'b1, {MANT_W{1'b0}}} : r_mant;
                    exp_q  <= exp_q + EW'(r_carry);
                    inex_q <= r_inex;
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    result    <= pk_res;
                    overflow  <= pk_ovf;
                    underflow <= pk_unf;
                    inexact   <= pk_inex;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: directed vectors, queue scoreboard, decoupled monitor.
// Expectations adapt when FP_SUBNORMAL_EN is defined.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        reset, start, sign_in;
    logic [9:0]  exp_in;
    logic [47:0] sig_in;
    logic        busy, done, overflow, underflow, inexact;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        int          issued;
        string       name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    fp_normalize_round dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .sig_in    (sig_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: result %0h with no request", result);
            end else begin
                e = q.pop_front();
                chk({e.name, "_result"}, 64'(result), 64'(e.res));
                chk({e.name, "_flags"}, 64'({overflow, underflow, inexact}), 64'(e.flg));
                chk({e.name, "_latency"}, 64'(cyc - e.issued - 1), 64'(e.lat));
            end
        end
    end

    task automatic issue(string nm, logic s, logic [9:0] e, logic [47:0] sg,
                         logic [31:0] r, logic [2:0] f, int lat, int hold, bit push);
        exp_t x;
        @(negedge clk);
        sign_in = s;
        exp_in  = e;
        sig_in  = sg;
        start   = 1'b1;
        if (push) begin
            x = '{r, f, lat, cyc, nm};
            q.push_back(x);
        end
        repeat (1 + hold) @(negedge clk);
        if (hold == 0) chk({nm, "_busy"}, 64'(busy), 64'(1));
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results pending", q.size());
            q.delete();
        end
    endtask

    task automatic run(string nm, logic s, logic [9:0] e, logic [47:0] sg,
                       logic [31:0] r, logic [2:0] f, int lat);
        issue(nm, s, e, sg, r, f, lat, 0, 1'b1);
        drain();
    endtask

    task automatic chk_idle(string nm);
        chk({nm, "_busy"}, 64'(busy), 64'(0));
        chk({nm, "_done"}, 64'(done), 64'(0));
        chk({nm, "_result"}, 64'(result), 64'(0));
        chk({nm, "_flags"}, 64'({overflow, underflow, inexact}), 64'(0));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        sign_in = 1'b0;
        exp_in  = '0;
        sig_in  = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;

        // flags are {overflow, underflow, inexact}
        run("one",      1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 3'b000, 3);
        run("rshift",   1'b0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 3'b000, 4);
        run("lshift2",  1'b0, 10'd130, 48'h1000_0000_0000, 32'h4000_0000, 3'b000, 5);
        run("tie_even", 1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001, 3);
        run("tie_odd",  1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 3'b001, 3);
        run("above",    1'b0, 10'd127, 48'h4000_0060_0000, 32'h3F80_0001, 3'b001, 3);
        run("carry",    1'b0, 10'd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 3'b001, 3);
        run("ovf_sh",   1'b0, 10'd254, 48'h8000_0000_0000, 32'h7F80_0000, 3'b100, 4);
        run("ovf_255",  1'b0, 10'd255, 48'h4000_0000_0000, 32'h7F80_0000, 3'b100, 3);
        run("maxexp",   1'b0, 10'd254, 48'h4000_0000_0000, 32'h7F00_0000, 3'b000, 3);
        run("neg1p5",   1'b1, 10'd128, 48'h6000_0000_0000, 32'hC040_0000, 3'b000, 3);
        run("zero",     1'b1, 10'd127, 48'h0,              32'h8000_0000, 3'b000, 2);
        run("worst",    1'b0, 10'd173, 48'h1,              32'h3F80_0000, 3'b000, 49);
`ifdef FP_SUBNORMAL_EN
        run("sub_inex", 1'b0, 10'd0,   48'h4000_0000_0001, 32'h0040_0000, 3'b011, 4);
        run("sub_neg",  1'b1, 10'h3FE, 48'h4000_0000_0000, 32'h8010_0000, 3'b000, 6);
`else
        run("unf_zero", 1'b0, 10'd0,   48'h4000_0000_0001, 32'h0000_0000, 3'b011, 3);
        run("unf_neg",  1'b1, 10'h3FE, 48'h4000_0000_0000, 32'h8000_0000, 3'b011, 3);
`endif

        // start held through the DONE cycle must not launch a second op
        issue("hold", 1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 3'b000, 3, 3, 1'b1);
        drain();
        repeat (10) @(negedge clk);

        // reset mid-shift aborts silently, then a new start works
        issue("abort", 1'b0, 10'd173, 48'h1, 32'h0, 3'b000, 0, 0, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        reset = 1'b0;
        repeat (60) @(negedge clk);
        run("after_rst", 1'b0, 10'd128, 48'h4000_0000_0000, 32'h4000_0000, 3'b000, 3);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
